mul32_seq: RTL and testbench

Sequential radix-4 Booth multiplier that produces a 64-bit product split into HI and LO words. It is the multiply counterpart of the combinational 32-bit divider and sits beside it in the ALU's mul/div unit, where its results feed the HI/LO registers. It trades the divider's single-cycle array for a 17-iteration datapath with a start/done handshake, and it supports both signed and unsigned operands.

---
 rtl/mul32_seq.sv | 121 ++++++++++++
 tb/tb_mul32_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mul32_seq.sv
// mul32_seq: sequential radix-4 Booth multiplier, 32x32 -> 64-bit HI/LO product.
// Handles signed and unsigned operands in 17 iterations with a start/done handshake.
module mul32_seq (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iStart,
    input  logic        iSigned,
    input  logic [31:0] iA,
    input  logic [31:0] iB,
    output logic        oBusy,
    output logic        oDone,
    output logic [31:0] oHi,
    output logic [31:0] oLo
);

    // state   | meaning
    // IDLE    | waiting for iStart
    // RUN     | one Booth step per edge, 17 steps total
    // DONE    | one-cycle result pulse; iStart here chains a new operation
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [34:0] r_m;
    logic [34:0] r_p;
    logic [33:0] r_q;
    logic        r_qm1;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_start;
    logic        w_last;
    logic [34:0] w_m2;
    logic [34:0] w_addend;
    logic [34:0] w_p_sum;
    logic [69:0] w_cat;
    logic [69:0] w_shift;

    assign w_start = iStart && (r_state != ST_RUN);
    assign w_last  = (r_cnt == 5'd16);

    // State register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (iStart) w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = iStart ? ST_RUN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Booth recoding of {Q[1],Q[0],q-1} into the addend for this step.
    // 2M cannot overflow 35 bits because M carries at most 33 significant bits.
    assign w_m2 = {r_m[33:0], 1'b0};
    always_comb begin
        w_addend = '0;
        case ({r_q[1:0], r_qm1})
            3'b001, 3'b010: w_addend = r_m;
            3'b011:         w_addend = w_m2;
            3'b100:         w_addend = ~w_m2 + 35'd1;
            3'b101, 3'b110: w_addend = ~r_m + 35'd1;
            default:        w_addend = '0;
        endcase
    end

    // Accumulate, then arithmetic shift {P,Q,q-1} right by two.
    assign w_p_sum = r_p + w_addend;
    assign w_cat   = {w_p_sum, r_q, r_qm1};
    assign w_shift = {{2{w_cat[69]}}, w_cat[69:2]};

    // Datapath: operand capture, iteration, and result register update.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_m   <= '0;
            r_p   <= '0;
            r_q   <= '0;
            r_qm1 <= 1'b0;
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else if (w_start) begin
            r_m   <= iSigned ? {{3{iA[31]}}, iA} : {3'b000, iA};
            r_q   <= iSigned ? {{2{iB[31]}}, iB} : {2'b00, iB};
            r_p   <= '0;
            r_qm1 <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            r_p   <= w_shift[69:35];
            r_q   <= w_shift[34:1];
            r_qm1 <= w_shift[0];
            r_cnt <= r_cnt + 5'd1;
            if (w_last) begin
                // Low 64 bits of the shifted {P,Q}.
                r_hi <= w_shift[64:33];
                r_lo <= w_shift[32:1];
            end
        end
    end

    assign oBusy = (r_state == ST_RUN);
    assign oDone = (r_state == ST_DONE);
    assign oHi   = r_hi;
    assign oLo   = r_lo;

endmodule

// File: tb/tb_mul32_seq.sv
// Self-checking bench for mul32_seq: directed cases plus a randomized sweep
// compared against a plain 64-bit arithmetic reference.
module tb_mul32_seq;

    logic        iClk;
    logic        iRst;
    logic        iStart;
    logic        iSigned;
    logic [31:0] iA;
    logic [31:0] iB;
    logic        oBusy;
    logic        oDone;
    logic [31:0] oHi;
    logic [31:0] oLo;

    int n_total = 0;
    int n_bad   = 0;

    mul32_seq dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iStart  (iStart),
        .iSigned (iSigned),
        .iA      (iA),
        .iB      (iB),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .oHi     (oHi),
        .oLo     (oLo)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint     sa;
        longint     sb;
        logic [63:0] ua;
        logic [63:0] ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return sa * sb;
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // One full operation: start, then watch latency, busy length, output stability.
    task automatic run_op(input string tag, input bit s, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        logic [31:0] hi0;
        logic [31:0] lo0;
        int          lat;
        int          busy_cnt;
        bit          stable;
        bit          both;
        @(negedge iClk);
        iStart  = 1'b1;
        iSigned = s;
        iA      = a;
        iB      = b;
        @(posedge iClk);
        @(negedge iClk);
        iStart  = 1'b0;
        iA      = $urandom;
        iB      = $urandom;
        iSigned = 1'($urandom_range(0, 1));
        hi0 = oHi;
        lo0 = oLo;
        lat = 0;
        busy_cnt = 0;
        stable = 1'b1;
        both = 1'b0;
        for (int i = 1; i <= 30 && lat == 0; i++) begin
            if (i > 1) @(negedge iClk);
            if (oBusy && oDone) both = 1'b1;
            if (oDone) begin
                lat = i;
            end else begin
                if (oBusy) busy_cnt++;
                if (oHi !== hi0 || oLo !== lo0) stable = 1'b0;
            end
        end
        chk({tag, ".latency"}, 64'(lat), 64'd18);
        chk({tag, ".busy_len"}, 64'(busy_cnt), 64'd17);
        chk({tag, ".stable"}, 64'(stable), 64'd1);
        chk({tag, ".busy_done_overlap"}, 64'(both), 64'd0);
        chk({tag, ".product"}, {oHi, oLo}, exp);
    endtask

    initial begin
        int          done_cnt;
        int          done_cyc [2];
        logic [63:0] done_val [2];
        bit          seen;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rs;

        iRst    = 1'b1;
        iStart  = 1'b0;
        iSigned = 1'b0;
        iA      = '0;
        iB      = '0;
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        chk("reset.busy", 64'(oBusy), 64'd0);
        chk("reset.done", 64'(oDone), 64'd0);
        chk("reset.hilo", {oHi, oLo}, 64'd0);
        iRst = 1'b0;

        run_op("s7x6", 1'b1, 32'd7, 32'd6, 64'h00000000_0000002A);
        run_op("s_m1xm1", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001);
        run_op("u_maxxmax", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        run_op("s_minxmin", 1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
        run_op("s_minx1", 1'b1, 32'h80000000, 32'd1, 64'hFFFFFFFF_80000000);

        // Ignored start during RUN, then back-to-back start held through DONE.
        @(negedge iClk);
        iStart = 1'b1; iSigned = 1'b0; iA = 32'd3; iB = 32'd5;
        @(posedge iClk);
        done_cnt = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge iClk);
            if (oDone) begin
                if (done_cnt < 2) begin
                    done_cyc[done_cnt] = cyc;
                    done_val[done_cnt] = {oHi, oLo};
                end
                done_cnt++;
            end
            case (cyc)
                1:  iStart = 1'b0;
                5:  begin iStart = 1'b1; iA = 32'd9; end
                6:  begin iStart = 1'b0; iA = 32'd3; end
                17: begin iStart = 1'b1; iA = 32'd2; iB = 32'd2; end
                19: iStart = 1'b0;
                default: ;
            endcase
        end
        chk("b2b.done_count", 64'(done_cnt), 64'd2);
        if (done_cnt >= 1) begin
            chk("b2b.first_cycle", 64'(done_cyc[0]), 64'd18);
            chk("b2b.first_val", done_val[0], 64'd15);
        end
        if (done_cnt >= 2) begin
            chk("b2b.second_gap", 64'(done_cyc[1] - done_cyc[0]), 64'd18);
            chk("b2b.second_val", done_val[1], 64'd4);
        end

        // Reset mid-operation aborts with no done pulse.
        @(negedge iClk);
        iStart = 1'b1; iSigned = 1'b0; iA = 32'h12345678; iB = 32'h9ABCDEF0;
        @(posedge iClk);
        seen = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge iClk);
            if (oDone) seen = 1'b1;
            if (cyc == 1) iStart = 1'b0;
            if (cyc == 10) iRst = 1'b1;
        end
        @(negedge iClk);
        chk("abort.busy", 64'(oBusy), 64'd0);
        chk("abort.hilo", {oHi, oLo}, 64'd0);
        iRst = 1'b0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge iClk);
            if (oDone) seen = 1'b1;
        end
        chk("abort.no_done", 64'(seen), 64'd0);
        run_op("after_abort", 1'b0, 32'h00010000, 32'h00010000, 64'h00000001_00000000);

        // Randomized sweep in both modes.
        for (int k = 0; k < 1000; k++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'(k & 1);
            if (k % 50 == 3) ra = 32'h80000000;
            if (k % 70 == 5) rb = 32'hFFFFFFFF;
            run_op("rand", rs, ra, rb, ref_mul(rs, ra, rb));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
